// File: rtl/fetch_stage0_pkg.sv
`include "bpf_defs.vh"
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage0_pkg : field offsets and PC-update selector for fetch   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package fetch_stage0_pkg;

    localparam int C_CODE_MSB = `BPF_CODE_MSB;
    localparam int C_CODE_LSB = `BPF_CODE_LSB;
    localparam int C_JT_MSB   = `BPF_JT_MSB;
    localparam int C_JT_LSB   = `BPF_JT_LSB;
    localparam int C_JF_MSB   = `BPF_JF_MSB;
    localparam int C_JF_LSB   = `BPF_JF_LSB;
    localparam int C_K_MSB    = `BPF_K_MSB;
    localparam int C_K_LSB    = `BPF_K_LSB;

    typedef enum logic [1:0] {
        PC_INCR   = 2'd0,
        PC_HOLD   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_HALT   = 2'd3
    } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/bpf_defs.vh
// Shared BPF instruction word field positions: [63:48] code, [47:40] jt, [39:32] jf, [31:0] k.
`default_nettype none
`ifndef BPF_DEFS_VH
`define BPF_DEFS_VH
`define BPF_CODE_MSB 63
`define BPF_CODE_LSB 48
`define BPF_JT_MSB   47
`define BPF_JT_LSB   40
`define BPF_JF_MSB   39
`define BPF_JF_LSB   32
`define BPF_K_MSB    31
`define BPF_K_LSB    0
`endif
`default_nettype wire

// File: rtl/fetch_perf_counters.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_perf_counters : saturating fetch / stall event counters       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (fetch_inc && (r_fetch_count != 32'hFFFF_FFFF))
                r_fetch_count <= r_fetch_count + 32'd1;
            if (stall_inc && (r_stall_count != 32'hFFFF_FFFF))
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage0.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage0 : BPF instruction fetch; optional FETCH_PERF_CNT_EN    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module fetch_stage0
    import fetch_stage0_pkg::*;
#(
    parameter int PC_WIDTH   = 10,
    parameter int INST_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stage1_stalled,
    input  logic                  branch_en,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  halt,
    output logic [PC_WIDTH-1:0]   inst_mem_rd_addr,
    output logic                  inst_mem_rd_en,
    input  logic [INST_WIDTH-1:0] inst_mem_rd_data,
    output logic [15:0]           opcode,
    output logic [7:0]            jt,
    output logic [7:0]            jf,
    output logic [31:0]           imm,
    output logic [PC_WIDTH-1:0]   inst_PC,
    output logic                  stage0_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_inst_pc;
    logic                r_valid;
    logic                r_halt;
    pc_sel_e             w_sel;

    // A sticky halt outranks everything but reset, so it is folded into the halt case.
    always_comb begin
        w_sel = PC_INCR;
        if (halt || r_halt)
            w_sel = PC_HALT;
        else if (branch_en)
            w_sel = PC_BRANCH;
        else if (stage1_stalled)
            w_sel = PC_HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
            r_halt    <= 1'b0;
        end else begin
            case (w_sel)
                PC_HALT: begin
                    r_halt  <= 1'b1;
                    r_valid <= 1'b0;
                end
                PC_BRANCH: begin
                    r_pc    <= branch_target;
                    r_valid <= 1'b0;
                end
                PC_HOLD: begin
                end
                default: begin
                    r_pc      <= r_pc + 1'b1;
                    r_inst_pc <= r_pc;
                    r_valid   <= 1'b1;
                end
            endcase
        end
    end

    assign inst_mem_rd_addr = r_pc;
    assign inst_mem_rd_en   = !r_halt && (branch_en || !stage1_stalled);

    assign opcode       = inst_mem_rd_data[C_CODE_MSB:C_CODE_LSB];
    assign jt           = inst_mem_rd_data[C_JT_MSB:C_JT_LSB];
    assign jf           = inst_mem_rd_data[C_JF_MSB:C_JF_LSB];
    assign imm          = inst_mem_rd_data[C_K_MSB:C_K_LSB];
    assign inst_PC      = r_inst_pc;
    assign stage0_valid = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic w_fetch_inc;
    logic w_stall_inc;

    assign w_fetch_inc = !rst && (w_sel == PC_INCR);
    assign w_stall_inc = !rst && stage1_stalled && r_valid;

    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .fetch_inc   (w_fetch_inc),
        .stall_inc   (w_stall_inc),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage0.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage0 : directed vector bench for fetch_stage0            |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_fetch_stage0;

    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          stage1_stalled;
    logic          branch_en;
    logic [PW-1:0] branch_target;
    logic          halt;
    logic [PW-1:0] rd_addr;
    logic          rd_en;
    logic [63:0]   rd_data = 64'd0;
    logic [15:0]   opcode;
    logic [7:0]    jt;
    logic [7:0]    jf;
    logic [31:0]   imm;
    logic [PW-1:0] inst_pc;
    logic          valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   fetch_count;
    logic [31:0]   stall_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_stage0 #(.PC_WIDTH(PW), .INST_WIDTH(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .stage1_stalled   (stage1_stalled),
        .branch_en        (branch_en),
        .branch_target    (branch_target),
        .halt             (halt),
        .inst_mem_rd_addr (rd_addr),
        .inst_mem_rd_en   (rd_en),
        .inst_mem_rd_data (rd_data),
        .opcode           (opcode),
        .jt               (jt),
        .jf               (jf),
        .imm              (imm),
        .inst_PC          (inst_pc),
        .stage0_valid     (valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count      (fetch_count),
        .stall_count      (stall_count)
`endif
    );

    // Instruction RAM: each word encodes its own address in every field.
    function automatic logic [63:0] mk_word(input logic [PW-1:0] a);
        mk_word = {6'd0, a, a[7:0], ~a[7:0], 32'hC0DE_0000 | {22'd0, a}};
    endfunction

    always @(posedge clk)
        if (rd_en) rd_data <= mk_word(rd_addr);

    typedef struct {
        logic          stall;
        logic          br;
        logic [PW-1:0] tgt;
        logic          hlt;
        logic          exp_rden;
        logic          exp_valid;
        logic [PW-1:0] exp_ipc;
        logic [PW-1:0] exp_addr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input vec_t v, input string tag);
        logic [63:0] w;
        stage1_stalled = v.stall;
        branch_en      = v.br;
        branch_target  = v.tgt;
        halt           = v.hlt;
        #1;
        check({tag, " rd_en"}, {63'd0, rd_en}, {63'd0, v.exp_rden});
        @(posedge clk);
        #1;
        check({tag, " valid"}, {63'd0, valid}, {63'd0, v.exp_valid});
        check({tag, " inst_PC"}, {54'd0, inst_pc}, {54'd0, v.exp_ipc});
        check({tag, " rd_addr"}, {54'd0, rd_addr}, {54'd0, v.exp_addr});
        if (v.exp_valid) begin
            w = mk_word(v.exp_ipc);
            check({tag, " fields"}, {opcode, jt, jf, imm}, w);
        end
        @(negedge clk);
    endtask

    // Reset asserted while a branch and a stall are both pending.
    task automatic do_reset();
        rst            = 1'b1;
        stage1_stalled = 1'b1;
        branch_en      = 1'b1;
        branch_target  = 10'h077;
        halt           = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset valid", {63'd0, valid}, 64'd0);
        check("reset inst_PC", {54'd0, inst_pc}, 64'd0);
        check("reset rd_addr", {54'd0, rd_addr}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("reset fetch_count", {32'd0, fetch_count}, 64'd0);
        check("reset stall_count", {32'd0, stall_count}, 64'd0);
`endif
        @(negedge clk);
        rst            = 1'b0;
        stage1_stalled = 1'b0;
        branch_en      = 1'b0;
        branch_target  = '0;
    endtask

    initial begin
        rst = 1'b1; stage1_stalled = 1'b0; branch_en = 1'b0; branch_target = '0; halt = 1'b0;

        //                 stall br  tgt     hlt  rden vld ipc     addr
        for (int i = 0; i < 6; i++)
            vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'(i), 10'(i + 1)});
        vq.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h005, 10'h006});
        vq.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h005, 10'h006});
        vq.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h005, 10'h006});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h006, 10'h007});
        vq.push_back('{1'b0, 1'b1, 10'h020, 1'b0, 1'b1, 1'b0, 10'h006, 10'h020});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h020, 10'h021});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h021, 10'h022});
        vq.push_back('{1'b1, 1'b1, 10'h040, 1'b0, 1'b1, 1'b0, 10'h021, 10'h040});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h040, 10'h041});
        vq.push_back('{1'b0, 1'b1, 10'h010, 1'b0, 1'b1, 1'b0, 10'h040, 10'h010});
        vq.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h040, 10'h010});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h010, 10'h011});
        vq.push_back('{1'b0, 1'b1, 10'h3FE, 1'b0, 1'b1, 1'b0, 10'h010, 10'h3FE});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h3FE, 10'h3FF});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h3FF, 10'h000});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h000, 10'h001});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, 10'h001});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h001});
        vq.push_back('{1'b0, 1'b1, 10'h055, 1'b0, 1'b0, 1'b0, 10'h000, 10'h001});
        vq.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h001});

        @(negedge clk);
        do_reset();
        foreach (vq[i]) step(vq[i], $sformatf("v%0d", i));
`ifdef FETCH_PERF_CNT_EN
        check("table fetch_count", {32'd0, fetch_count}, 64'd14);
        check("table stall_count", {32'd0, stall_count}, 64'd4);
`endif

        // Reset out of the halted state, then 10 fetches followed by 4 stall cycles.
        do_reset();
        for (int i = 0; i < 10; i++)
            step('{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'(i), 10'(i + 1)},
                 $sformatf("run%0d", i));
        for (int i = 0; i < 4; i++)
            step('{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h009, 10'h00A},
                 $sformatf("hold%0d", i));
`ifdef FETCH_PERF_CNT_EN
        check("run fetch_count", {32'd0, fetch_count}, 64'd10);
        check("run stall_count", {32'd0, stall_count}, 64'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage0.md
FETCH_STAGE0 -- requirements
Module: fetch_stage0

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, instruction memory address width.
REQ-002 SHALL have parameter INST_WIDTH, default 64, instruction word width; only 64 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stage1_stalled  input  1  downstream decode stage is holding its instruction.
REQ-006 SHALL have port branch_en  input  1  taken jump from stage2 redirects fetch.
REQ-007 SHALL have port branch_target  input  PC_WIDTH  new PC when branch_en=1.
REQ-008 SHALL have port halt  input  1  program returned; fetch stops until rst.
REQ-009 SHALL have port inst_mem_rd_addr  output  PC_WIDTH  equals the PC register, combinational.
REQ-010 SHALL have port inst_mem_rd_en  output  1  synchronous-read enable (1-cycle latency RAM).
REQ-011 SHALL have port inst_mem_rd_data  input  64  instruction word: [63:48] code, [47:40] jt, [39:32] jf, [31:0] k.
REQ-012 SHALL have ports opcode 16, jt 8, jf 8, imm 32 (outputs), wired directly from the inst_mem_rd_data fields.
REQ-013 SHALL have port inst_PC  output  PC_WIDTH  PC of the instruction currently on opcode/jt/jf/imm.
REQ-014 SHALL have port stage0_valid  output  1  opcode/jt/jf/imm/inst_PC hold a real, unsquashed instruction.

Function
REQ-015 SHALL update the PC with priority rst > halt > branch_en > stage1_stalled > increment.
REQ-016 SHALL assert inst_mem_rd_en = !halt_q && (branch_en || !stage1_stalled).
REQ-017 SHALL, on increment, set PC <= PC+1 modulo 2^PC_WIDTH (max value wraps to 0), inst_PC <= PC, stage0_valid <= 1.
REQ-018 SHALL, while stage1_stalled=1 and no branch, hold PC, inst_PC, stage0_valid; RAM output holds because rd_en=0.
REQ-019 SHALL, on branch_en at cycle T, set PC <= branch_target and stage0_valid <= 0; T+1 valid=0; T+2 valid=1 with inst_PC=branch_target.
REQ-020 SHALL let branch_en override a simultaneous stage1_stalled (the stalled instruction is squashed).
REQ-021 SHALL, on halt, set sticky halt_q <= 1, stage0_valid <= 0, and freeze PC; halt_q clears only on rst.
REQ-022 SHALL give first valid instruction (inst_PC=0) in the cycle after rst deasserts +1 (one bubble).

Reset
REQ-023 SHALL reset PC=0, inst_PC=0, stage0_valid=0, halt_q=0; rst mid-branch or mid-stall discards both.
REQ-024 SHALL drive inst_mem_rd_en=1 in the first cycle after reset (reading address 0).

Configuration
REQ-025 SHALL, with FETCH_PERF_CNT_EN defined, add outputs fetch_count[31:0] (increments per cycle that stage0_valid goes or stays 1 with a new instruction) and stall_count[31:0] (increments per cycle stage1_stalled=1 && stage0_valid=1), both saturating at 0xFFFFFFFF and reset to 0.
REQ-026 SHALL, without FETCH_PERF_CNT_EN, omit those ports and counters entirely.

Structure
REQ-027 SHALL take instruction field bit positions (code/jt/jf/k offsets) from bpf_defs.vh as shared constants.
REQ-028 SHALL place the counters in sub-module fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-029 SHALL cover: rst then free-run, RAM[n]=n -> valid rises 2 cycles post-reset, inst_PC 0,1,2,... each cycle.
REQ-030 SHALL cover: stage1_stalled=1 for 3 cycles at inst_PC=5 -> outputs hold inst_PC=5, then inst_PC=6.
REQ-031 SHALL cover: branch_en with target 0x20 at T -> valid=0 at T+1, inst_PC=0x20 valid=1 at T+2.
REQ-032 SHALL cover: branch_en and stage1_stalled together -> branch wins, same timing as REQ-031.
REQ-033 SHALL cover: PC=0x3FF increment -> next inst_PC=0x000; halt -> valid=0 permanently until rst.
REQ-034 SHALL cover (FETCH_PERF_CNT_EN): 10 fetches + 4 stall cycles -> fetch_count=10, stall_count=4.
